// File: rtl/intermed_wire_monitor.sv
// Edge-counting observer for the AND/OR gating stage with a valid/ready result.
// Define INTERMED_MON_CHECK_EN to enable the sticky illegal-combination flag.
module intermed_wire_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_and,
    input  logic             in_or,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] and_cnt,
    output logic [CNT_W-1:0] or_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT
    } state_e;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] and_q, and_d;
    logic [CNT_W-1:0] or_q, or_d;
    logic             s_and_q, s_and_q2;
    logic             s_or_q, s_or_q2;
    logic             edge_and, edge_or;

    assign edge_and = s_and_q & ~s_and_q2;
    assign edge_or  = s_or_q & ~s_or_q2;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        and_d   = and_q;
        or_d    = or_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero length still opens a one-cycle window.
                    win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
                    and_d   = '0;
                    or_d    = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (edge_and && and_q != '1) begin
                    and_d = and_q + CNT_W'(1);
                end
                if (edge_or && or_q != '1) begin
                    or_d = or_q + CNT_W'(1);
                end
                win_d = win_q - WIN_W'(1);
                if (win_q == WIN_W'(1)) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            and_q    <= '0;
            or_q     <= '0;
            s_and_q  <= 1'b0;
            s_and_q2 <= 1'b0;
            s_or_q   <= 1'b0;
            s_or_q2  <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            and_q    <= and_d;
            or_q     <= or_d;
            s_and_q  <= in_and;
            s_and_q2 <= s_and_q;
            s_or_q   <= in_or;
            s_or_q2  <= s_or_q;
        end
    end

`ifdef INTERMED_MON_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (s_and_q && !s_or_q) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign res_valid = (state_q == REPORT);
    assign and_cnt   = and_q;
    assign or_cnt    = or_q;

endmodule

// File: tb/tb_intermed_wire_monitor.sv
// Scoreboard bench: window model from input history, monitor on res_valid.
// Runs an 8-bit and a 4-bit counter instance side by side.
module tb_intermed_wire_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_and = 1'b0;
    logic       in_or = 1'b0;
    logic       start = 1'b0;
    logic [7:0] win_len = '0;
    logic       res_ready = 1'b0;

    logic       res_valid, err;
    logic [7:0] and_cnt, or_cnt;
    logic       res_valid4, err4;
    logic [3:0] and_cnt4, or_cnt4;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    intermed_wire_monitor #(.CNT_W(8), .WIN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_and(in_and), .in_or(in_or),
        .start(start), .win_len(win_len),
        .res_ready(res_ready), .res_valid(res_valid),
        .and_cnt(and_cnt), .or_cnt(or_cnt), .err(err)
    );

    intermed_wire_monitor #(.CNT_W(4), .WIN_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_and(in_and), .in_or(in_or),
        .start(start), .win_len(win_len),
        .res_ready(res_ready), .res_valid(res_valid4),
        .and_cnt(and_cnt4), .or_cnt(or_cnt4), .err(err4)
    );

    typedef struct {
        int a8;
        int o8;
        int a4;
        int o4;
    } res_t;

    res_t q[$];
    res_t last;
    res_t cur;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference: a window opened at edge t with length l counts every rise
    // whose sample pair (edges e-2, e-1) lands inside edges t+1 .. t+l.
    int  n = 0;
    bit  busy = 0;
    int  t0 = 0;
    int  len = 0;
    int  ac = 0;
    int  oc = 0;
    bit  valid_exp = 0;
    bit  err_m = 0;
    bit  pa1 = 0, pa2 = 0, po1 = 0, po2 = 0;

    always @(posedge clk) begin
        n++;
        if (!rst_n) begin
            busy = 0;
            valid_exp = 0;
            err_m = 0;
            pa1 = 0; pa2 = 0; po1 = 0; po2 = 0;
            last = '{0, 0, 0, 0};
            q.delete();
        end else begin
            if (busy && n > t0 && n <= t0 + len) begin
                ac += int'(pa1 & ~pa2);
                oc += int'(po1 & ~po2);
            end
            if (pa1 && !po1) err_m = 1;
            if (!busy && start) begin
                busy = 1;
                t0 = n;
                len = (win_len == 0) ? 1 : int'(win_len);
                ac = 0;
                oc = 0;
            end else if (busy && n == t0 + len) begin
                last = '{sat(ac, 8), sat(oc, 8), sat(ac, 4), sat(oc, 4)};
                q.push_back(last);
                valid_exp = 1;
            end else if (busy && n > t0 + len && res_ready) begin
                busy = 0;
                valid_exp = 0;
            end
            pa2 = pa1; pa1 = in_and;
            po2 = po1; po1 = in_or;
        end
    end

    bit prev_v = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("res_valid", res_valid, valid_exp);
            chk("res_valid4", res_valid4, valid_exp);
`ifdef INTERMED_MON_CHECK_EN
            chk("err", err, err_m);
`else
            chk("err", err, 0);
`endif
            if (res_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("and_cnt", and_cnt, cur.a8);
                    chk("or_cnt", or_cnt, cur.o8);
                    chk("and_cnt4", and_cnt4, cur.a4);
                    chk("or_cnt4", or_cnt4, cur.o4);
                end
            end else if (res_valid) begin
                chk("and_hold", and_cnt, cur.a8);
                chk("or_hold", or_cnt, cur.o8);
            end else if (!busy) begin
                chk("and_idle", and_cnt, last.a8);
                chk("or_idle", or_cnt, last.o8);
                chk("or_idle4", or_cnt4, last.o4);
            end
            prev_v = res_valid;
        end
    end

    task automatic drv(bit a, bit o, bit st, logic [7:0] wl, bit rdy, bit rn);
        @(negedge clk);
        in_and = a;
        in_or = o;
        start = st;
        win_len = wl;
        res_ready = rdy;
        rst_n = rn;
    endtask

    task automatic idle(int k, bit rdy);
        for (int i = 0; i < k; i++) drv(0, 0, 0, 0, rdy, 1);
    endtask

    bit pa[10];
    bit po[10];

    initial begin
        for (int i = 0; i < 3; i++) drv(i[0], 1, 1, 5, 1, 0);
        idle(6, 1);

        pa = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        po = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        drv(0, 0, 1, 10, 0, 1);
        for (int i = 0; i < 10; i++) drv(pa[i], po[i], 0, 0, 0, 1);
        idle(5, 0);
        chk("basic_valid", res_valid, 1);
        chk("basic_or", or_cnt, 3);
        chk("basic_and", and_cnt, 1);
        idle(3, 1);

        drv(0, 0, 1, 60, 0, 1);
        for (int i = 0; i < 60; i++) drv(0, i[0], 0, 0, 0, 1);
        idle(3, 0);
        chk("sat_or4", or_cnt4, 15);
        chk("sat_or8", or_cnt, 29);
        idle(3, 1);

        drv(0, 1, 1, 0, 0, 1);
        idle(4, 0);
        idle(3, 1);

        drv(0, 0, 1, 5, 0, 1);
        drv(0, 0, 1, 3, 0, 1);
        drv(0, 0, 1, 3, 0, 1);
        idle(5, 0);
        drv(0, 0, 1, 2, 1, 1);
        idle(10, 1);

        for (int i = 0; i < 4; i++) drv(0, 1, 0, 0, 1, 1);
        drv(0, 1, 1, 6, 1, 1);
        for (int i = 0; i < 8; i++) drv(0, 1, 0, 0, 1, 1);
        idle(4, 1);

        drv(0, 0, 1, 10, 1, 1);
        for (int i = 0; i < 3; i++) drv(1, 1, 0, 0, 1, 1);
        drv(0, 1, 0, 0, 1, 0);
        idle(14, 1);

        drv(1, 0, 0, 0, 1, 1);
        idle(2, 1);
        drv(0, 0, 1, 4, 1, 1);
        idle(8, 1);
`ifdef INTERMED_MON_CHECK_EN
        chk("err_sticky", err, 1);
`else
        chk("err_tied", err, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit o, a;
            o = 1'($urandom);
            a = o & 1'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                a = 1;
                o = 0;
            end
            drv(a, o,
                $urandom_range(0, 5) == 0,
                8'($urandom_range(0, 40)),
                1'($urandom),
                $urandom_range(0, 299) != 0);
        end
        idle(80, 1);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
